// File: rtl/sfq_toggle_deserializer.sv
// Capture stage for toggle-encoded RSFQ gate models: decides per cell-clock window whether the
// gate fired, packs decisions into words and delivers them through a small FIFO.
module sfq_toggle_deserializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk_t,
  input  logic             sfq_q_t,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_stray,
  output logic             err_multi,
  output logic             overflow,
  output logic [CNT_W-1:0] pulse_count
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);
  localparam logic [AW:0]     FullCnt = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StOpen} state_e;

  state_e            state_q, state_d;
  logic              prev_c, prev_q;
  logic              c_edge, q_edge;
  logic [1:0]        hit_q, hit_d, hits_inc;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d, push_word;
  logic              push, do_push, pop, full;
  logic              stray_q, stray_d, multi_q, multi_d, ovf_q;
  logic [CNT_W-1:0]  pcnt_q;
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Edges are masked during reset; prev registers still track the inputs so none appear after.
  assign c_edge = !rst && (sfq_clk_t != prev_c);
  assign q_edge = !rst && (sfq_q_t != prev_q);

  // A q pulse coinciding with a clock edge belongs to the window being closed.
  assign hits_inc = (q_edge && hit_q != 2'd2) ? hit_q + 2'd1 : hit_q;

  always_comb begin
    state_d   = state_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    stray_d   = stray_q;
    multi_d   = multi_q;
    push      = 1'b0;
    push_word = '0;
    unique case (state_q)
      StIdle: begin
        if (q_edge) stray_d = 1'b1;
        if (c_edge) begin
          state_d = StOpen;
          hit_d   = 2'd0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      StOpen: begin
        if (c_edge) begin
          shift_d[idx_q] = (hits_inc != 2'd0);
          if (hits_inc == 2'd2) multi_d = 1'b1;
          hit_d = 2'd0;
          if (idx_q == LastIdx) begin
            push      = 1'b1;
            push_word = shift_d;
            shift_d   = '0;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          hit_d = hits_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign full    = (cnt_q == FullCnt);
  assign pop     = out_valid && out_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    prev_c <= sfq_clk_t;
    prev_q <= sfq_q_t;
    if (rst) begin
      state_q <= StIdle;
      hit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      stray_q <= 1'b0;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
      pcnt_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      stray_q <= stray_d;
      multi_q <= multi_d;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (q_edge && pcnt_q != '1) pcnt_q <= pcnt_q + CNT_W'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      if (do_push) wr_q <= wr_q + AW'(1);
      unique case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_word;
  end

  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? mem[rd_q] : '0;
  assign err_stray   = stray_q;
  assign err_multi   = multi_q;
  assign overflow    = ovf_q;
  assign pulse_count = pcnt_q;

endmodule

// File: tb/tb_sfq_toggle_deserializer.sv
// Directed bench for sfq_toggle_deserializer: windows are 3 clk cycles, expectations hand-computed.
module tb_sfq_toggle_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sfq_clk_t = 1'b0;
  logic        sfq_q_t = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_stray, err_multi, overflow;
  logic [15:0] pulse_count;

  int n_vec = 0;
  int n_err = 0;

  sfq_toggle_deserializer #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .sfq_clk_t   (sfq_clk_t),
    .sfq_q_t     (sfq_q_t),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_stray   (err_stray),
    .err_multi   (err_multi),
    .overflow    (overflow),
    .pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // First clock edge opens window 0.
  task automatic start();
    sfq_clk_t = ~sfq_clk_t;
    tick();
  endtask

  // One 3-cycle window with nq q pulses; sim adds a q pulse on the closing clock edge.
  task automatic win(input int nq, input bit sim);
    for (int k = 0; k < nq; k++) begin
      sfq_q_t = ~sfq_q_t;
      tick();
    end
    for (int k = nq; k < 2; k++) tick();
    sfq_clk_t = ~sfq_clk_t;
    if (sim) sfq_q_t = ~sfq_q_t;
    tick();
  endtask

  task automatic send_word(input logic [7:0] bits);
    for (int i = 0; i < 8; i++) win(int'(bits[i]), 1'b0);
  endtask

  task automatic check_flags(input string tag, input logic s, input logic m, input logic o);
    check_eq({tag, "_stray"}, 32'(err_stray), 32'(s));
    check_eq({tag, "_multi"}, 32'(err_multi), 32'(m));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    // Reset behaviour: inputs toggle under reset, final levels c=1 q=0.
    tick();
    sfq_clk_t = 1'b1; sfq_q_t = 1'b1; tick();
    sfq_clk_t = 1'b0; tick();
    sfq_q_t = 1'b0; sfq_clk_t = 1'b1; tick();
    rst = 1'b0;
    tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_pcnt", 32'(pulse_count), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);

    // Basic packing: pulses in windows 0, 2, 5 -> 0x25.
    start();
    for (int i = 0; i < 7; i++) win((i == 0 || i == 2 || i == 5) ? 1 : 0, 1'b0);
    tick(); tick();
    sfq_clk_t = ~sfq_clk_t;
    check_eq("basic_prevalid", 32'(out_valid), 32'd0);
    tick();
    check_eq("basic_valid", 32'(out_valid), 32'd1);
    check_eq("basic_data", 32'(out_data), 32'h25);
    check_eq("basic_pcnt", 32'(pulse_count), 32'd3);
    check_flags("basic", 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_eq("basic_popped", 32'(out_valid), 32'd0);

    // Stray pulse before the first clock edge.
    do_reset();
    sfq_q_t = ~sfq_q_t; tick(); tick();
    start();
    send_word(8'h00);
    check_eq("stray_valid", 32'(out_valid), 32'd1);
    check_eq("stray_data", 32'(out_data), 32'h00);
    check_eq("stray_pcnt", 32'(pulse_count), 32'd1);
    check_flags("stray", 1'b1, 1'b0, 1'b0);

    // Multi-hit in window 0, simultaneous edges closing window 7.
    do_reset();
    start();
    win(2, 1'b0);
    for (int i = 1; i < 7; i++) win(0, 1'b0);
    win(0, 1'b1);
    check_eq("multi_valid", 32'(out_valid), 32'd1);
    check_eq("multi_data", 32'(out_data), 32'h81);
    check_eq("multi_pcnt", 32'(pulse_count), 32'd3);
    check_flags("multi", 1'b0, 1'b1, 1'b0);

    // Backpressure: five words into a 4-deep FIFO.
    do_reset();
    start();
    for (int w = 1; w <= 4; w++) send_word(8'(w));
    check_eq("bp_no_ovf_yet", 32'(overflow), 32'd0);
    send_word(8'h05);
    check_eq("bp_ovf", 32'(overflow), 32'd1);
    tick();
    check_eq("bp_hold_data", 32'(out_data), 32'h01);
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      check_eq($sformatf("bp_drain_valid%0d", w), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp_drain_data%0d", w), 32'(out_data), 32'(w));
      tick();
    end
    out_ready = 1'b0;
    check_eq("bp_empty", 32'(out_valid), 32'd0);
    check_eq("bp_empty_data", 32'(out_data), 32'd0);

    // Mid-word reset after four committed ones.
    do_reset();
    start();
    for (int i = 0; i < 4; i++) win(1, 1'b0);
    check_eq("mid_pcnt_pre", 32'(pulse_count), 32'd4);
    do_reset();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    start();
    send_word(8'h00);
    check_eq("mid_valid", 32'(out_valid), 32'd1);
    check_eq("mid_data", 32'(out_data), 32'h00);
    check_eq("mid_pcnt", 32'(pulse_count), 32'd0);
    check_flags("mid", 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_eq("mid_one_entry", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfq_toggle_deserializer.md
Name: sfq_toggle_deserializer

Overview:
- Downstream capture stage for clocked RSFQ gate models such as the two-input clocked AND cell. Those gates signal one SFQ pulse as one toggle of a wire, and emit output after their cell clock.
- The block watches the gate's cell-clock toggle line and output toggle line in the synchronous verification domain. It decides, for each cell-clock cycle, whether the gate fired.
- It packs the results into words, buffers them in a small FIFO, and delivers them over a valid/ready interface. Error and overflow flags and a pulse counter feed the characterisation bench.

Parameters:
- WIDTH, 8, decisions (bits) per output word.
- DEPTH, 4, output FIFO depth in words; power of two, at least 2.
- CNT_W, 16, pulse counter width.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  synchronous reset, active-high.
- sfq_clk_t  input  1  toggle-encoded cell clock; any level change is one clock pulse. Already synchronous to clk.
- sfq_q_t  input  1  toggle-encoded gate output; any level change is one output pulse. Already synchronous to clk.
- out_data  output  WIDTH  packed decisions; bit 0 is the oldest window.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- err_stray  output  1  sticky; a q pulse arrived before the first cell-clock pulse.
- err_multi  output  1  sticky; more than one q pulse arrived in one window.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
- pulse_count  output  CNT_W  total q pulses since reset; saturates at all-ones.

Behaviour:
- Edge detection: prev_c and prev_q registers.
  - A clock edge is detected when sfq_clk_t != prev_c at posedge clk; a q edge when sfq_q_t != prev_q.
  - prev registers update every cycle.
  - During rst they load the current input levels, so no false edge is seen after reset.
- Reset: out_valid, err_*, overflow, pulse_count, shift register, bit index and FIFO pointers all clear to 0; the FSM goes to IDLE. out_data reads 0 while the FIFO is empty.
- FSM states: IDLE (no cell-clock edge seen since reset) and OPEN (a window is in progress).
  - IDLE:
    - On a clock edge, go to OPEN, clear pending and hit_cnt, bit_idx=0; no bit is committed.
    - On a q edge, set err_stray and increment pulse_count; no bit is recorded.
  - OPEN:
    - On a q edge, increment hit_cnt (saturating at 2) and increment pulse_count.
    - On a clock edge, commit bit = (hit_cnt != 0) into shift[bit_idx], then bit_idx++. Set err_multi if hit_cnt was 2. Start a new window with hit_cnt=0.
- Simultaneous clock edge and q edge in one cycle: the q pulse is credited to the closing window, because gate output lags its clock.
- Word completion: the commit with bit_idx == WIDTH-1 forms the word and pushes it to the FIFO on that same posedge; bit_idx wraps to 0.
- Push latency: out_valid is high in the cycle after the posedge that detected the closing clock edge (registered FIFO).
- FIFO:
  - Pop when out_valid && out_ready.
  - A push while full succeeds only if a pop happens in the same cycle. Otherwise the word is dropped and overflow is set.
  - out_data and out_valid are stable while out_valid && !out_ready.
  - Order is strictly FIFO.
- Counters: pulse_count saturates and does not wrap. Sticky flags clear only on rst.
- Reset mid-word: the partial word is discarded, the FIFO is emptied and the FSM returns to IDLE.

Test Plan:
- Reset behaviour: toggle both inputs while rst=1, then release. All outputs must be 0, with no edge detected in the first cycle after release.
- Basic packing: apply 9 clock toggles spaced 3 cycles apart, with q toggling 1 cycle after clock edges 1, 3 and 6 (windows 0, 2 and 5). Required: out_data=0x25, out_valid rises one cycle after edge 9, pulse_count=3, no flags set.
- Stray pulse: toggle q once, then apply 9 clock toggles. Required: err_stray=1, pulse_count=1, word=0x00.
- Multi-hit: toggle q twice within window 0 and toggle clock in the same cycle as a q toggle in window 7. Required: word=0x81, err_multi=1, pulse_count=3.
- Backpressure: hold out_ready=0 and complete 5 words (0x01..0x05) with DEPTH=4. Required: overflow=1; then with out_ready=1, the bench drains exactly 0x01..0x04 in order.
- Mid-word reset: after 4 committed bits, assert rst for 1 cycle, then apply 9 clean clock edges. Required: only one word, 0x00, FIFO holds 1 entry, flags clear.
